// File: rtl/spi_slave.sv
// SPI responder: oversamples nCS/DCLK/MOSI, honours CPOL/CPHA, exchanges 8-bit MSB-first frames.
// Define SPI_SLAVE_FRAME_ERR_EN to add frame_err, a pulse for frames cut short by nCS.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       nCS,
  input  logic       DCLK,
  input  logic       MOSI,
  output logic       MISO,
  output logic       miso_oe,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic [SYNC_STAGES-1:0] dclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   ncs_prev;
  logic                   dclk_prev;
  logic [CNT_W-1:0]       bit_cnt;
  logic [BYTE_W-2:0]      rx_shift;
  logic [BYTE_W-1:0]      tx_shift;
  logic [BYTE_W-1:0]      tx_buf;

  logic ncs_s, dclk_s, mosi_s;
  logic ncs_fall, ncs_rise, dclk_rise, dclk_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge, load_now;

  assign ncs_s  = ncs_sync[SYNC_STAGES-1];
  assign dclk_s = dclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign MISO   = tx_shift[BYTE_W-1];
  assign busy   = (state == ACTIVE);

  // Edge classification against the previous synced values
  always_comb begin
    ncs_fall    = ~ncs_s & ncs_prev;
    ncs_rise    = ncs_s & ~ncs_prev;
    dclk_rise   = dclk_s & ~dclk_prev;
    dclk_fall   = ~dclk_s & dclk_prev;
    lead_edge   = CPOL ? dclk_fall : dclk_rise;
    trail_edge  = CPOL ? dclk_rise : dclk_fall;
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    // CPHA=0 must present bit 7 before the first edge, so it loads on nCS falling
    load_now    = ((state == IDLE) && ncs_fall && !CPHA) ||
                  ((state == ACTIVE) && !ncs_rise && shift_edge && (bit_cnt == '0));
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      ncs_sync  <= '1;
      dclk_sync <= '0;
      mosi_sync <= '0;
      ncs_prev  <= 1'b1;
      dclk_prev <= 1'b0;
      miso_oe   <= 1'b0;
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_buf    <= '0;
      tx_ready  <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], DCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ncs_prev  <= ncs_s;
      dclk_prev <= dclk_s;
      // Tracks the synced nCS of the same cycle, one stage early
      miso_oe   <= ~ncs_sync[SYNC_STAGES-2];
      rx_valid  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif

      // Transmit buffer: a load point drains it, otherwise tx_load fills it when empty
      if (load_now) begin
        if (!tx_ready) begin
          tx_shift <= tx_buf;
          tx_ready <= 1'b1;
        end else if (tx_load) begin
          tx_shift <= tx_data;
        end else begin
          tx_shift <= '0;
        end
      end else if (tx_load && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state   <= ACTIVE;
            bit_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (ncs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err <= (bit_cnt != '0);
`endif
          end else begin
            if (sample_edge) begin
              rx_shift <= {rx_shift[BYTE_W-3:0], mosi_s};
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(7)) begin
                rx_data  <= {rx_shift, mosi_s};
                rx_valid <= 1'b1;
              end
            end
            if (shift_edge && (bit_cnt != '0)) begin
              tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: table of single-byte mode exchanges, hand-written corner
// sequences and randomized windows checked against a byte-level transfer model.
module tb_spi_slave;
  localparam int H = 8;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b0;
  logic       nCS     = 1'b1;
  logic       DCLK    = 1'b0;
  logic       MOSI    = 1'b0;
  logic       CPOL    = 1'b0;
  logic       CPHA    = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       MISO, miso_oe, tx_ready, rx_valid, busy;
  logic [7:0] rx_data;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
  int         ferr_cnt = 0;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] rxq[$];
  logic       prev_valid = 1'b0;

  // Window description shared by the window tasks
  int         w_n;
  logic [7:0] w_mo[4];
  logic [7:0] w_td[4];
  logic [7:0] w_mi[4];
  bit         w_ld[4];

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] mosi;
    logic [7:0] tx;
    bit         load;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t tbl[6];

  always #5 sys_clk = ~sys_clk;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .nCS      (nCS),
    .DCLK     (DCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .miso_oe  (miso_oe),
    .CPOL     (CPOL),
    .CPHA     (CPHA),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  // Received-byte monitor: collects every rx_valid pulse and checks it is one cycle wide
  always @(negedge sys_clk) begin
    if (rx_valid) begin
      checks++;
      if (prev_valid) begin
        failures++;
        $display("FAIL rx_valid_width: actual=2+ cycles required=1 cycle");
      end
      rxq.push_back(rx_data);
    end
    prev_valid = rx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (frame_err) ferr_cnt++;
`endif
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%02h required=0x%02h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    CPOL = pol;
    CPHA = pha;
    DCLK = pol;
    cyc(2 * H);
  endtask

  task automatic open_win();
    nCS = 1'b0;
    cyc(H);
    chk1("miso_oe_active", miso_oe, 1'b1);
    chk1("busy_active", busy, 1'b1);
  endtask

  task automatic close_win();
    cyc(H);
    nCS = 1'b1;
    cyc(2 * H);
  endtask

  // Master side of one byte; optionally queues the next tx byte early in the byte
  task automatic xfer_byte(input logic [7:0] mo, input bit nxt, input logic [7:0] nxt_d,
                           output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      if (i == 6 && nxt) pulse_load(nxt_d);
      if (!CPHA) begin
        MOSI = mo[i];
        cyc(H);
        mi[i] = MISO;
        DCLK = ~CPOL;
        cyc(H);
        DCLK = CPOL;
      end else begin
        DCLK = ~CPOL;
        MOSI = mo[i];
        cyc(H);
        mi[i] = MISO;
        DCLK = CPOL;
        cyc(H);
      end
    end
  endtask

  task automatic run_win();
    logic [7:0] mi;
    rxq.delete();
    if (w_ld[0]) begin
      pulse_load(w_td[0]);
      chk1("tx_ready_after_load", tx_ready, 1'b0);
    end
    open_win();
    for (int k = 0; k < w_n; k++) begin
      xfer_byte(w_mo[k], (k + 1 < w_n) && w_ld[k + 1], w_td[k + 1], mi);
      w_mi[k] = mi;
    end
    close_win();
  endtask

  // Model: the slave returns the loaded bytes in order, 0x00 for an underrun byte
  task automatic check_win(input string tag);
    for (int k = 0; k < w_n; k++)
      chk8($sformatf("%s_miso%0d", tag, k), w_mi[k], w_ld[k] ? w_td[k] : 8'h00);
    chkn($sformatf("%s_rx_count", tag), rxq.size(), w_n);
    if (rxq.size() == w_n)
      for (int k = 0; k < w_n; k++)
        chk8($sformatf("%s_rx%0d", tag, k), rxq[k], w_mo[k]);
    chk1($sformatf("%s_tx_ready", tag), tx_ready, 1'b1);
    chk1($sformatf("%s_busy_idle", tag), busy, 1'b0);
    chk1($sformatf("%s_miso_oe_idle", tag), miso_oe, 1'b0);
  endtask

  initial begin
    logic [7:0] last_rx;
    logic [7:0] mi;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    int ferr_before;
`endif
    tbl[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 8'h3C, 8'hA5};
    tbl[1] = '{1'b0, 1'b1, 8'h5A, 8'hC3, 1'b1, 8'hC3, 8'h5A};
    tbl[2] = '{1'b1, 1'b0, 8'h5A, 8'hC3, 1'b1, 8'hC3, 8'h5A};
    tbl[3] = '{1'b1, 1'b1, 8'h5A, 8'hC3, 1'b1, 8'hC3, 8'h5A};
    tbl[4] = '{1'b0, 1'b0, 8'h3C, 8'h77, 1'b0, 8'h00, 8'h3C};
    tbl[5] = '{1'b1, 1'b1, 8'h96, 8'h77, 1'b0, 8'h00, 8'h96};

    // Reset values
    cyc(3);
    chk1("rst_miso", MISO, 1'b0);
    chk1("rst_miso_oe", miso_oe, 1'b0);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_tx_ready", tx_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b1;
    cyc(4);

    // Single-byte exchanges in every mode, with and without a preloaded byte
    for (int t = 0; t < 6; t++) begin
      set_mode(tbl[t].cpol, tbl[t].cpha);
      w_n = 1;
      w_mo[0] = tbl[t].mosi;
      w_td[0] = tbl[t].tx;
      w_ld[0] = tbl[t].load;
      run_win();
      chk8($sformatf("tbl%0d_miso", t), w_mi[0], tbl[t].exp_miso);
      chkn($sformatf("tbl%0d_rx_count", t), rxq.size(), 1);
      if (rxq.size() == 1) chk8($sformatf("tbl%0d_rx", t), rxq[0], tbl[t].exp_rx);
      chk8($sformatf("tbl%0d_rx_data", t), rx_data, tbl[t].exp_rx);
      chk1($sformatf("tbl%0d_tx_ready", t), tx_ready, 1'b1);
      chk1($sformatf("tbl%0d_busy", t), busy, 1'b0);
    end

    // Two bytes in one window, second tx byte queued during the first
    set_mode(1'b0, 1'b0);
    w_n = 2;
    w_mo[0] = 8'h11; w_mo[1] = 8'h22;
    w_td[0] = 8'h3C; w_td[1] = 8'h99;
    w_ld[0] = 1'b1;  w_ld[1] = 1'b1;
    run_win();
    check_win("two_byte");

    // A second tx_load while the buffer is full is dropped
    pulse_load(8'h3C);
    pulse_load(8'h55);
    w_n = 1; w_mo[0] = 8'hE1; w_ld[0] = 1'b0;
    rxq.delete();
    open_win();
    xfer_byte(w_mo[0], 1'b0, 8'h00, mi);
    close_win();
    chk8("full_load_first_kept", mi, 8'h3C);
    w_td[0] = 8'h00;
    w_mo[0] = 8'h0F;
    run_win();
    check_win("full_load_dropped");

    // nCS raised after five sample edges: partial byte is discarded
    last_rx = rx_data;
    rxq.delete();
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ferr_before = ferr_cnt;
`endif
    open_win();
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1;
      cyc(H);
      DCLK = 1'b1;
      cyc(H);
      DCLK = 1'b0;
    end
    close_win();
    chkn("abort_no_rx_valid", rxq.size(), 0);
    chk8("abort_rx_data_held", rx_data, last_rx);
    chk1("abort_busy", busy, 1'b0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chkn("abort_frame_err", ferr_cnt - ferr_before, 1);
`endif
    w_n = 1; w_mo[0] = 8'h6D; w_ld[0] = 1'b0; w_td[0] = 8'h00;
    run_win();
    check_win("after_abort");

    // Randomized windows: mode, length, data and tx preloads
    for (int r = 0; r < 20; r++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      w_n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        w_mo[k] = 8'($urandom);
        w_td[k] = 8'($urandom);
        w_ld[k] = 1'($urandom_range(0, 1));
      end
      run_win();
      check_win($sformatf("rnd%0d", r));
    end

    // Reset asserted mid-byte
    set_mode(1'b0, 1'b0);
    pulse_load(8'hFF);
    open_win();
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1;
      cyc(H);
      DCLK = 1'b1;
      cyc(H);
      DCLK = 1'b0;
    end
    pulse_load(8'h42);
    cyc(H);
    rst = 1'b0;
    #1;
    chk1("midrst_miso", MISO, 1'b0);
    chk1("midrst_miso_oe", miso_oe, 1'b0);
    chk8("midrst_rx_data", rx_data, 8'h00);
    chk1("midrst_rx_valid", rx_valid, 1'b0);
    chk1("midrst_tx_ready", tx_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    nCS  = 1'b1;
    DCLK = 1'b0;
    MOSI = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(2 * H);
    w_n = 1; w_mo[0] = 8'hF0; w_ld[0] = 1'b1; w_td[0] = 8'hA9;
    run_win();
    check_win("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
